// File: rtl/pit_ctrl_sequencer.sv
// pit_ctrl_sequencer: bus-side control and sequencing for a three-counter 8254 timer.
// Turns CPU byte writes into control words and 16-bit initial counts, and serves
// the counter-latch command and byte-ordered readback of each counter.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   cs, wr, rd            chip select and one-cycle write/read strobes
//   addr, din             register select (3 = control word) and write data
//   cur0..cur2            live count value of each counter
//   count0..count2        initial count presented to each counter
//   new_count             one-cycle pulse per counter when its count is complete
//   cfg_wr                one-cycle pulse per counter on a mode-setting control word
//   mode0..mode2, bcd     per-counter mode (0-5) and BCD flag
//   dout                  registered read data, holds until the next read
module pit_ctrl_sequencer #(
    parameter int unsigned NUM_CNT = 3,
    parameter int unsigned CW      = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cs,
    input  logic          wr,
    input  logic          rd,
    input  logic [1:0]    addr,
    input  logic [7:0]    din,
    input  logic [CW-1:0] cur0,
    input  logic [CW-1:0] cur1,
    input  logic [CW-1:0] cur2,
    output logic [CW-1:0] count0,
    output logic [CW-1:0] count1,
    output logic [CW-1:0] count2,
    output logic [2:0]    new_count,
    output logic [2:0]    cfg_wr,
    output logic [2:0]    mode0,
    output logic [2:0]    mode1,
    output logic [2:0]    mode2,
    output logic [2:0]    bcd,
    output logic [7:0]    dout
);

    localparam int unsigned NC     = 3;
    localparam int unsigned BW     = 8;
    localparam logic [1:0]  CW_ADR = 2'b11;
    localparam logic [1:0]  RW_LAT = 2'b00;
    localparam logic [1:0]  RW_LSB = 2'b01;
    localparam logic [1:0]  RW_MSB = 2'b10;
    localparam logic [1:0]  RW_16  = 2'b11;

    // Per-counter state
    logic [CW-1:0] count_q [NC];
    logic [CW-1:0] count_d [NC];
    logic [2:0]    mode_q  [NC];
    logic [2:0]    mode_d  [NC];
    logic [1:0]    rw_q    [NC];
    logic [1:0]    rw_d    [NC];
    logic [BW-1:0] lsb_q   [NC];
    logic [BW-1:0] lsb_d   [NC];
    logic [CW-1:0] latch_q [NC];
    logic [CW-1:0] latch_d [NC];
    logic [NC-1:0] wff_q, wff_d;
    logic [NC-1:0] rff_q, rff_d;
    logic [NC-1:0] latched_q, latched_d;
    logic [NC-1:0] bcd_q, bcd_d;
    logic [NC-1:0] new_count_q, new_count_d;
    logic [NC-1:0] cfg_wr_q, cfg_wr_d;
    logic [BW-1:0] dout_q, dout_d;

    logic [CW-1:0] cur [NC];
    logic          wr_en;
    logic          rd_en;
    logic [1:0]    cw_sc;
    logic [1:0]    cw_rw;
    logic [2:0]    cw_mode;
    logic [CW-1:0] rd_src;

    assign cur[0] = cur0;
    assign cur[1] = cur1;
    assign cur[2] = cur2;

    // A write wins over a simultaneous read
    assign wr_en = cs & wr;
    assign rd_en = cs & rd & ~wr;

    // Control-word fields; modes 6/7 alias to 2/3
    assign cw_sc   = din[7:6];
    assign cw_rw   = din[5:4];
    assign cw_mode = (din[3:2] == 2'b11) ? {1'b0, din[2:1]} : din[3:1];

    // Next-state decode of writes, control words and reads
    always_comb begin
        count_d     = count_q;
        mode_d      = mode_q;
        rw_d        = rw_q;
        lsb_d       = lsb_q;
        latch_d     = latch_q;
        wff_d       = wff_q;
        rff_d       = rff_q;
        latched_d   = latched_q;
        bcd_d       = bcd_q;
        new_count_d = '0;
        cfg_wr_d    = '0;
        dout_d      = dout_q;
        rd_src      = '0;

        if (wr_en) begin
            if (addr == CW_ADR) begin
                // SC=3 is the read-back command, which this block does not support
                for (int i = 0; i < int'(NC); i++) begin
                    if (cw_sc == 2'(i)) begin
                        if (cw_rw == RW_LAT) begin
                            // First latch holds until the value has been read out
                            if (!latched_q[i]) begin
                                latch_d[i]   = cur[i];
                                latched_d[i] = 1'b1;
                            end
                        end else begin
                            rw_d[i]      = cw_rw;
                            mode_d[i]    = cw_mode;
                            bcd_d[i]     = din[0];
                            wff_d[i]     = 1'b0;
                            rff_d[i]     = 1'b0;
                            latched_d[i] = 1'b0;
                            cfg_wr_d[i]  = 1'b1;
                        end
                    end
                end
            end else begin
                for (int i = 0; i < int'(NC); i++) begin
                    if (addr == 2'(i)) begin
                        unique case (rw_q[i])
                            RW_LSB: begin
                                count_d[i]     = {8'h00, din};
                                new_count_d[i] = 1'b1;
                            end
                            RW_MSB: begin
                                count_d[i]     = {din, 8'h00};
                                new_count_d[i] = 1'b1;
                            end
                            RW_16: begin
                                if (!wff_q[i]) begin
                                    lsb_d[i] = din;
                                    wff_d[i] = 1'b1;
                                end else begin
                                    count_d[i]     = {din, lsb_q[i]};
                                    wff_d[i]       = 1'b0;
                                    new_count_d[i] = 1'b1;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
            end
        end else if (rd_en) begin
            if (addr == CW_ADR) begin
                dout_d = 8'h00;
            end else begin
                for (int i = 0; i < int'(NC); i++) begin
                    if (addr == 2'(i)) begin
                        // Unlatched 16-bit reads sample live count per byte and may tear
                        rd_src = latched_q[i] ? latch_q[i] : cur[i];
                        unique case (rw_q[i])
                            RW_LSB: begin
                                dout_d       = rd_src[7:0];
                                latched_d[i] = 1'b0;
                            end
                            RW_MSB: begin
                                dout_d       = rd_src[15:8];
                                latched_d[i] = 1'b0;
                            end
                            RW_16: begin
                                if (!rff_q[i]) begin
                                    dout_d   = rd_src[7:0];
                                    rff_d[i] = 1'b1;
                                end else begin
                                    dout_d       = rd_src[15:8];
                                    rff_d[i]     = 1'b0;
                                    latched_d[i] = 1'b0;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
            end
        end
    end

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NC); i++) begin
                count_q[i] <= '0;
                mode_q[i]  <= '0;
                rw_q[i]    <= RW_LSB;
                lsb_q[i]   <= '0;
                latch_q[i] <= '0;
            end
            wff_q       <= '0;
            rff_q       <= '0;
            latched_q   <= '0;
            bcd_q       <= '0;
            new_count_q <= '0;
            cfg_wr_q    <= '0;
            dout_q      <= '0;
        end else begin
            count_q     <= count_d;
            mode_q      <= mode_d;
            rw_q        <= rw_d;
            lsb_q       <= lsb_d;
            latch_q     <= latch_d;
            wff_q       <= wff_d;
            rff_q       <= rff_d;
            latched_q   <= latched_d;
            bcd_q       <= bcd_d;
            new_count_q <= new_count_d;
            cfg_wr_q    <= cfg_wr_d;
            dout_q      <= dout_d;
        end
    end

    assign count0    = count_q[0];
    assign count1    = count_q[1];
    assign count2    = count_q[2];
    assign mode0     = mode_q[0];
    assign mode1     = mode_q[1];
    assign mode2     = mode_q[2];
    assign bcd       = bcd_q;
    assign new_count = new_count_q;
    assign cfg_wr    = cfg_wr_q;
    assign dout      = dout_q;

endmodule

// File: tb/tb_pit_ctrl_sequencer.sv
// Directed bench for pit_ctrl_sequencer: control words, count assembly, latch/readback, reset.
module tb_pit_ctrl_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cs = 1'b0;
    logic        wr = 1'b0;
    logic        rd = 1'b0;
    logic [1:0]  addr = 2'b00;
    logic [7:0]  din = 8'h00;
    logic [15:0] cur0 = 16'h0000;
    logic [15:0] cur1 = 16'h0000;
    logic [15:0] cur2 = 16'h0000;
    logic [15:0] count0, count1, count2;
    logic [2:0]  new_count, cfg_wr, mode0, mode1, mode2, bcd;
    logic [7:0]  dout;

    int pass_cnt = 0;
    int total_cnt = 0;

    pit_ctrl_sequencer dut (
        .clk(clk), .rst_n(rst_n), .cs(cs), .wr(wr), .rd(rd), .addr(addr), .din(din),
        .cur0(cur0), .cur1(cur1), .cur2(cur2),
        .count0(count0), .count1(count1), .count2(count2),
        .new_count(new_count), .cfg_wr(cfg_wr),
        .mode0(mode0), .mode1(mode1), .mode2(mode2), .bcd(bcd), .dout(dout)
    );

    always #5 clk = ~clk;

    // One bus cycle; returns 1 time unit after the sampling edge
    task automatic bus(input logic w, input logic r, input logic [1:0] a, input logic [7:0] d);
        @(negedge clk);
        cs = 1'b1; wr = w; rd = r; addr = a; din = d;
        @(posedge clk);
        #1;
        cs = 1'b0; wr = 1'b0; rd = 1'b0;
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        idle();
        total_cnt++;
        if ({count0, count1, count2} !== 48'h0) $display("FAIL reset_counts got %h exp 0", {count0, count1, count2});
        else pass_cnt++;
        total_cnt++;
        if ({new_count, cfg_wr, mode0, mode1, mode2, bcd, dout} !== 26'h0)
            $display("FAIL reset_ctrl got %h exp 0", {new_count, cfg_wr, mode0, mode1, mode2, bcd, dout});
        else pass_cnt++;
    endtask

    task automatic test_cnt0_word();
        bus(1, 0, 2'b11, 8'h34);
        total_cnt++;
        if (cfg_wr !== 3'b001 || mode0 !== 3'd2) $display("FAIL cw34 cfg_wr=%b mode0=%0d exp 001/2", cfg_wr, mode0);
        else pass_cnt++;
        bus(1, 0, 2'b00, 8'hE8);
        total_cnt++;
        if (new_count !== 3'b000 || count0 !== 16'h0000 || cfg_wr !== 3'b000)
            $display("FAIL lsb_stage new_count=%b count0=%h cfg_wr=%b exp 000/0000/000", new_count, count0, cfg_wr);
        else pass_cnt++;
        bus(1, 0, 2'b00, 8'h03);
        total_cnt++;
        if (new_count !== 3'b001 || count0 !== 16'h03E8)
            $display("FAIL word16 new_count=%b count0=%h exp 001/03e8", new_count, count0);
        else pass_cnt++;
        idle();
        total_cnt++;
        if (new_count !== 3'b000) $display("FAIL pulse_width new_count=%b exp 000", new_count);
        else pass_cnt++;
    endtask

    task automatic test_cnt1_bytes();
        bus(1, 0, 2'b11, 8'h50);
        total_cnt++;
        if (cfg_wr !== 3'b010 || mode1 !== 3'd0) $display("FAIL cw50 cfg_wr=%b mode1=%0d exp 010/0", cfg_wr, mode1);
        else pass_cnt++;
        bus(1, 0, 2'b01, 8'h05);
        total_cnt++;
        if (count1 !== 16'h0005 || new_count !== 3'b010)
            $display("FAIL lsb_only count1=%h new_count=%b exp 0005/010", count1, new_count);
        else pass_cnt++;
        bus(1, 0, 2'b11, 8'h60);
        bus(1, 0, 2'b01, 8'h12);
        total_cnt++;
        if (count1 !== 16'h1200 || new_count !== 3'b010)
            $display("FAIL msb_only count1=%h new_count=%b exp 1200/010", count1, new_count);
        else pass_cnt++;
    endtask

    task automatic test_latch();
        bus(1, 0, 2'b11, 8'hB0);
        cur2 = 16'hABCD;
        bus(1, 0, 2'b11, 8'h80);
        cur2 = 16'h1111;
        bus(1, 0, 2'b11, 8'h80);
        bus(0, 1, 2'b10, 8'h00);
        total_cnt++;
        if (dout !== 8'hCD) $display("FAIL latch_lsb dout=%h exp cd", dout);
        else pass_cnt++;
        bus(0, 1, 2'b10, 8'h00);
        total_cnt++;
        if (dout !== 8'hAB) $display("FAIL latch_msb dout=%h exp ab", dout);
        else pass_cnt++;
        bus(0, 1, 2'b10, 8'h00);
        total_cnt++;
        if (dout !== 8'h11) $display("FAIL live_after_latch dout=%h exp 11", dout);
        else pass_cnt++;
        bus(0, 1, 2'b11, 8'h00);
        total_cnt++;
        if (dout !== 8'h00) $display("FAIL read_ctrl_addr dout=%h exp 00", dout);
        else pass_cnt++;
    endtask

    task automatic test_mode_alias();
        bus(1, 0, 2'b11, 8'h3E);
        total_cnt++;
        if (mode0 !== 3'd3) $display("FAIL mode7 mode0=%0d exp 3", mode0);
        else pass_cnt++;
        bus(1, 0, 2'b11, 8'h3C);
        total_cnt++;
        if (mode0 !== 3'd2) $display("FAIL mode6 mode0=%0d exp 2", mode0);
        else pass_cnt++;
        bus(1, 0, 2'b11, 8'hC0);
        total_cnt++;
        if (cfg_wr !== 3'b000 || mode0 !== 3'd2 || mode1 !== 3'd0 || mode2 !== 3'd0 || count0 !== 16'h03E8)
            $display("FAIL readback_ignored cfg_wr=%b modes=%0d%0d%0d count0=%h exp 000/200/03e8",
                     cfg_wr, mode0, mode1, mode2, count0);
        else pass_cnt++;
        bus(1, 0, 2'b11, 8'h39);
        total_cnt++;
        if (bcd !== 3'b001 || mode0 !== 3'd4) $display("FAIL bcd_flag bcd=%b mode0=%0d exp 001/4", bcd, mode0);
        else pass_cnt++;
    endtask

    task automatic test_wff_clear();
        bus(1, 0, 2'b11, 8'h3C);
        bus(1, 0, 2'b00, 8'h22);
        bus(1, 0, 2'b11, 8'h30);
        total_cnt++;
        if (cfg_wr !== 3'b001 || bcd !== 3'b000) $display("FAIL cw30 cfg_wr=%b bcd=%b exp 001/000", cfg_wr, bcd);
        else pass_cnt++;
        bus(1, 0, 2'b00, 8'h44);
        total_cnt++;
        if (new_count !== 3'b000 || count0 !== 16'h03E8)
            $display("FAIL wff_cleared new_count=%b count0=%h exp 000/03e8", new_count, count0);
        else pass_cnt++;
        bus(1, 0, 2'b00, 8'h55);
        total_cnt++;
        if (new_count !== 3'b001 || count0 !== 16'h5544)
            $display("FAIL word_after_cw new_count=%b count0=%h exp 001/5544", new_count, count0);
        else pass_cnt++;
    endtask

    task automatic test_async_reset();
        bus(1, 0, 2'b11, 8'h34);
        bus(1, 0, 2'b00, 8'h11);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        total_cnt++;
        if (count0 !== 16'h0000 || mode0 !== 3'd0 || count1 !== 16'h0000)
            $display("FAIL async_reset count0=%h mode0=%0d count1=%h exp 0000/0/0000", count0, mode0, count1);
        else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        // rw is back to LSB-only after reset, so a lone byte completes a count
        bus(1, 0, 2'b00, 8'h66);
        total_cnt++;
        if (count0 !== 16'h0066 || new_count !== 3'b001)
            $display("FAIL rw_after_reset count0=%h new_count=%b exp 0066/001", count0, new_count);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        cur0 = 16'h00A5;
        bus(0, 1, 2'b00, 8'h00);
        total_cnt++;
        if (dout !== 8'hA5) $display("FAIL rd_lsb dout=%h exp a5", dout);
        else pass_cnt++;
        cur0 = 16'h00FF;
        bus(1, 1, 2'b00, 8'h07);
        total_cnt++;
        if (count0 !== 16'h0007 || new_count !== 3'b001 || dout !== 8'hA5)
            $display("FAIL rd_wr_same count0=%h new_count=%b dout=%h exp 0007/001/a5", count0, new_count, dout);
        else pass_cnt++;
        bus(1, 0, 2'b01, 8'h09);
        total_cnt++;
        if (count1 !== 16'h0009 || count0 !== 16'h0007 || count2 !== 16'h0000 || new_count !== 3'b010)
            $display("FAIL independence c0=%h c1=%h c2=%h nc=%b exp 0007/0009/0000/010",
                     count0, count1, count2, new_count);
        else pass_cnt++;
        cs = 1'b0;
        @(negedge clk);
        wr = 1'b1; addr = 2'b00; din = 8'hEE;
        @(posedge clk);
        #1;
        wr = 1'b0;
        total_cnt++;
        if (count0 !== 16'h0007 || new_count !== 3'b000)
            $display("FAIL cs_low count0=%h new_count=%b exp 0007/000", count0, new_count);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_cnt0_word();
        test_cnt1_bytes();
        test_latch();
        test_mode_alias();
        test_wff_clear();
        test_async_reset();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/pit_ctrl_sequencer.md
Name: pit_ctrl_sequencer

Overview:
Bus-side control and sequencing block for the three-counter 8254 timer. It decodes CPU byte writes into control words, per-counter mode, BCD and read/write format. It assembles 8-bit writes into 16-bit initial counts and pulses each counter's new-count strobe. It also implements the counter-latch command and the byte-ordered readback of counter values.

Parameters:
NUM_CNT, 3, number of counters served (fixed 3; addr 11 = control word)
CW, 16, count width

Ports:
clk  in  1  system clock, all state on posedge
rst_n  in  1  asynchronous active-low reset
cs  in  1  chip select, active high; wr/rd ignored when low
wr  in  1  write strobe, one cycle, sampled at posedge
rd  in  1  read strobe, one cycle, sampled at posedge
addr  in  2  00/01/10 = counter 0/1/2, 11 = control word
din  in  8  write data
cur0, cur1, cur2  in  16 each  live count value from each counter
count0, count1, count2  out  16 each  initial count to each counter
new_count  out  3  one-cycle pulse per counter when its count is complete
cfg_wr  out  3  one-cycle pulse per counter on a mode-setting control word
mode0, mode1, mode2  out  3 each  counter mode 0-5
bcd  out  3  per-counter BCD flag (pass-through, not validated)
dout  out  8  read data, registered

Behaviour:
- Reset (async, rst_n=0):
  - count* = 0, new_count = 0, cfg_wr = 0, mode* = 0, bcd = 0, dout = 0.
  - Per counter: rw = 01, write flip-flop (wff) = 0, read flip-flop (rff) = 0, latched = 0, lsb_stage = 0, latch_reg = 0.
- Access qualification: an access occurs only when cs=1.
  - wr and rd in the same cycle: the write executes and the read is ignored.
  - new_count and cfg_wr are high for exactly the cycle after the qualifying posedge.
- Control word (wr, addr=11): SC = din[7:6], RW = din[5:4], M = din[3:1], BCD = din[0].
  - SC=11 (read-back): ignored, no state change.
  - RW=00 (latch command): if latched=0, then latch_reg = cur_SC and latched = 1. If latched=1, the command is ignored; the first latched value holds. mode, rw and flip-flops are unchanged.
  - RW≠00 (configure): rw = RW. mode = M, except M[2:1]=11 maps to {1'b0, M[1:0]}, i.e. 6→2 and 7→3. bcd = BCD. wff, rff and latched all clear. cfg_wr[SC] pulses. count_SC is unchanged and new_count is not pulsed.
- Count write (wr, addr=i≠11), by rw:
  - 01: count_i = {8'h00, din}; new_count[i] pulses.
  - 10: count_i = {din, 8'h00}; new_count[i] pulses.
  - 11, wff=0: lsb_stage = din, wff = 1; no pulse.
  - 11, wff=1: count_i = {din, lsb_stage}, wff = 0, new_count[i] pulses.
- Read (rd, addr=i≠11): source = latched ? latch_reg : cur_i. dout updates at the same posedge (valid the following cycle) and holds until the next read.
  - rw 01: dout = src[7:0]; latched clears.
  - rw 10: dout = src[15:8]; latched clears.
  - rw 11, rff=0: dout = src[7:0], rff = 1.
  - rw 11, rff=1: dout = src[15:8], rff = 0, latched clears.
  - Latched value is frozen; live cur_i is sampled per byte, so an unlatched 16-bit read may tear (matches 8254).
- Read at addr=11: dout = 8'h00.
- Independence: counters never share wff, rff or latch state. A write to one counter leaves every other counter's state unchanged.
- Reset asserted mid-sequence (wff or rff set, or latched=1) returns all state to reset values immediately.

Test Plan:
1. Reset, then wr addr=11 din=8'h34 (cnt0, RW=11, mode 2); wr addr=00 8'hE8; wr addr=00 8'h03 → cfg_wr=001 once; mode0=2; count0=16'h03E8 with a single new_count[0] pulse after the second byte only.
2. wr 11←8'h50 (cnt1, RW=01, mode 0), wr 01←8'h05 → count1=16'h0005, new_count=010 for one cycle. Then wr 11←8'h60 (RW=10), wr 01←8'h12 → count1=16'h1200.
3. cnt2 in RW=11 with cur2=16'hABCD; wr 11←8'h80 (latch); change cur2 to 16'h1111; second latch command → read 10 twice gives 8'hCD, 8'hAB. A third read gives 8'h11 (live value, latch released).
4. wr 11←8'h3E (M=111) → mode0=3. wr 11←8'h3C (M=110) → mode0=2. Then wr 11←8'hC0 (read-back) → no change anywhere.
5. cnt0 RW=11: write LSB 8'h22, then wr 11←8'h30 → wff clears. Next writes 8'h44, 8'h55 give count0=16'h5544.
6. Write LSB to cnt0 (wff=1), pull rst_n low asynchronously mid-cycle → count0=0 and mode0=0 immediately. Simultaneous rd+wr to addr 00 (rw=01, din=8'h07) → count0=16'h0007 and dout unchanged.
